mux_nto1_rr: RTL and testbench
==============================

Name: mux_nto1_rr

Overview:
- Parametrised, registered N-to-1 channel multiplexer. Successor to the 5-bit 2-to-1 datapath mux.
- Generalises width and channel count, adds a valid/ready handshake, one output register stage, and a round-robin arbitration mode next to the legacy direct-select mode.
- Used where several datapath producers share one destination register/bus, e.g. writeback source or register-destination selection in the multicycle/pipelined datapath.

Parameters:
- WIDTH, 5, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SELW, $clog2(CHANNELS), select/channel-index width; derived, do not override.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = direct select, 1 = round-robin arbitration.
- sel  input  SELW  channel index used in direct mode; ignored in RR mode.
- in_valid  input  CHANNELS  per-channel valid; bit i belongs to channel i.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  per-channel accept (combinational); at most one bit set.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_chan  output  SELW  index of the channel that produced out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. In-flight beat discarded; in_ready all 0 while in reset.
- load_ok = !out_valid || out_ready. A beat transfers on channel g when in_valid[g] && in_ready[g] at a rising edge.
- Latency: 1 cycle; out_data/out_chan update on the edge after acceptance. Full throughput (1 beat/cycle) when out_ready is held high.
- Stall: while out_valid && !out_ready, out_data/out_chan hold stable and in_ready is all 0.
- Direct mode (mode=0):
  - in_ready[sel] = load_ok; all other bits are 0.
  - If sel >= CHANNELS, no channel is ready and nothing is accepted.
  - rr_ptr is unchanged.
- RR mode (mode=1):
  - Grant g is the first i with in_valid[i] set, scanning from rr_ptr upward modulo CHANNELS.
  - in_ready[g] = load_ok.
  - On acceptance, rr_ptr <= (g+1) mod CHANNELS; wrap from CHANNELS-1 goes to 0.
  - No valid inputs: no grant, rr_ptr holds.
- Output register: out_valid <= 1 on acceptance; otherwise out_valid <= 0 when out_ready is high; otherwise it holds.
- Simultaneous drain and load (out_valid && out_ready && new accept): the new beat replaces the old one in the same edge, so no bubble is inserted.
- Mode change: takes effect on the grant of the same cycle. rr_ptr is retained across direct-mode periods. A beat already in the output register is unaffected.
- Combinational paths: in_valid/sel/mode/out_ready -> in_ready. There is no combinational path from in_data to out_data.

Optional Feature:
- Macro: MUX_RR_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - In RR mode, a beat accepted with lock=1 pins the grant to that channel (locked=1).
  - While locked, only that channel can be granted, even if it deasserts valid; other channels wait.
  - The lock clears on the first accepted beat from that channel with lock=0; rr_ptr then advances normally.
  - locked resets to 0. locked is ignored and cleared in direct mode.
- Not defined: no lock port; pure round-robin as above.

Test Plan:
- Reset/latency: WIDTH=5, CHANNELS=4, mode=0, sel=1, in_data ch0=10101, ch1=01010, in_valid=0010, out_ready=1. Release rst_n -> in_ready=0010; next edge out_valid=1, out_data=01010, out_chan=1. Assert rst_n low mid-stream -> out_valid=0, out_data=00000 immediately.
- Direct-mode invalid select: CHANNELS=3, sel=3, all valid -> in_ready=000, out_valid falls to 0 after the drain.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1. Then in_valid=1001 with rr_ptr=2 -> grants 3, 0, 3.
- Backpressure: out_ready=0 with a beat held (out_data=10101) -> in_ready=0000 and out_data stable for 5 cycles. Raise out_ready -> next beat loads the same edge, no bubble.
- Mode switch: RR with rr_ptr=2, switch to mode=0 sel=0 for 2 beats (out_chan=0,0), back to RR with all valid -> next grant is 2.
- Lock (MUX_RR_LOCK_EN): RR, all valid, ch1 accepted with lock=1 -> next 3 grants are ch1. ch1 then sends lock=0 -> following grant is 2.

Source files
------------

// File: rtl/mux_nto1_rr_if.sv
// Handshake bundle between producers/consumer and the N-to-1 round-robin mux.
// Carries the lock qualifier only when MUX_RR_LOCK_EN is defined.
interface mux_nto1_rr_if #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);

    logic                      mode;
    logic [SELW-1:0]           sel;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_chan;
    logic                      out_ready;
`ifdef MUX_RR_LOCK_EN
    logic                      lock;
`endif

    modport master (
`ifdef MUX_RR_LOCK_EN
        output lock,
`endif
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
`ifdef MUX_RR_LOCK_EN
        input  lock,
`endif
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/mux_nto1_rr.sv
// Registered N-to-1 mux with direct-select and round-robin arbitration modes.
// Optional grant locking in round-robin mode is enabled by defining MUX_RR_LOCK_EN.
module mux_nto1_rr #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4
) (
    input logic           clk,
    input logic           rst_n,
    mux_nto1_rr_if.slave  bus
);
    localparam int SELW = $clog2(CHANNELS);

    logic [SELW-1:0]     rr_ptr;
    logic [SELW-1:0]     grant;
    logic [SELW-1:0]     cand;
    logic                grant_vld;
    logic                load_ok;
    logic                accept;
    logic [CHANNELS-1:0] ready;

    logic                vld_p0;
    logic [WIDTH-1:0]    data_p0;
    logic [SELW-1:0]     chan_p0;

`ifdef MUX_RR_LOCK_EN
    logic                locked;
    logic [SELW-1:0]     lock_chan;
`endif

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] idx, input int step);
        int s;
        s = int'(idx) + step;
        if (s >= CHANNELS) s = s - CHANNELS;
        return SELW'(s);
    endfunction

    // Reset gating keeps every channel un-ready while rst_n is low.
    assign load_ok = rst_n && (!vld_p0 || bus.out_ready);

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        if (!bus.mode) begin
            if (int'(bus.sel) < CHANNELS) begin
                grant     = bus.sel;
                grant_vld = 1'b1;
            end
        end
`ifdef MUX_RR_LOCK_EN
        else if (locked) begin
            grant     = lock_chan;
            grant_vld = 1'b1;
        end
`endif
        else begin
            // Scan downward so the nearest valid channel after rr_ptr wins last.
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                cand = wrap_inc(rr_ptr, k);
                if (bus.in_valid[cand]) begin
                    grant     = cand;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        if (grant_vld && load_ok) ready[grant] = 1'b1;
    end

    assign accept       = grant_vld && load_ok && bus.in_valid[grant];
    assign bus.in_ready = ready;

    // Stage p0: output register, replaced in place when draining and loading together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            chan_p0 <= '0;
            rr_ptr  <= '0;
        end else begin
            if (accept) begin
                vld_p0  <= 1'b1;
                data_p0 <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
                chan_p0 <= grant;
            end else if (bus.out_ready) begin
                vld_p0  <= 1'b0;
            end
            if (accept && bus.mode) rr_ptr <= wrap_inc(grant, 1);
        end
    end

`ifdef MUX_RR_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked    <= 1'b0;
            lock_chan <= '0;
        end else if (!bus.mode) begin
            locked    <= 1'b0;
        end else if (accept) begin
            if (bus.lock) begin
                locked    <= 1'b1;
                lock_chan <= grant;
            end else begin
                locked    <= 1'b0;
            end
        end
    end
`endif

    assign bus.out_valid = vld_p0;
    assign bus.out_data  = data_p0;
    assign bus.out_chan  = chan_p0;
endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: a 4-channel and a 3-channel instance.
// Lock scenario is compiled in only with MUX_RR_LOCK_EN.
module tb_mux_nto1_rr;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mux_nto1_rr_if #(.WIDTH(5), .CHANNELS(4)) bus4 ();
    mux_nto1_rr_if #(.WIDTH(5), .CHANNELS(3)) bus3 ();

    mux_nto1_rr #(.WIDTH(5), .CHANNELS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    mux_nto1_rr #(.WIDTH(5), .CHANNELS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    localparam logic [4:0] D0 = 5'b10101;
    localparam logic [4:0] D1 = 5'b01010;
    localparam logic [4:0] D2 = 5'b00111;
    localparam logic [4:0] D3 = 5'b11000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] chan_data(input int c);
        case (c)
            0: return D0;
            1: return D1;
            2: return D2;
            default: return D3;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus4.mode = 1'b0; bus4.sel = 2'd1; bus4.in_valid = 4'b0010; bus4.out_ready = 1'b1;
        bus4.in_data = {D3, D2, D1, D0};
        bus3.mode = 1'b0; bus3.sel = 2'd0; bus3.in_valid = 3'b000; bus3.out_ready = 1'b1;
        bus3.in_data = {D2, D1, D0};
`ifdef MUX_RR_LOCK_EN
        bus4.lock = 1'b0; bus3.lock = 1'b0;
`endif
        #2;
        vectors++;
        if (bus4.in_ready !== 4'b0000) begin
            miscompares++; $display("FAIL reset_in_ready got %b want 0000", bus4.in_ready);
        end
        vectors++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 5'd0 || bus4.out_chan !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_out got v=%b d=%b c=%0d want v=0 d=00000 c=0",
                     bus4.out_valid, bus4.out_data, bus4.out_chan);
        end
        #1 rst_n = 1'b1;
        #1;
        vectors++;
        if (bus4.in_ready !== 4'b0010) begin
            miscompares++; $display("FAIL release_in_ready got %b want 0010", bus4.in_ready);
        end
        tick();
        vectors++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== D1 || bus4.out_chan !== 2'd1) begin
            miscompares++;
            $display("FAIL first_beat got v=%b d=%b c=%0d want v=1 d=01010 c=1",
                     bus4.out_valid, bus4.out_data, bus4.out_chan);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 5'd0 || bus4.in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset got v=%b d=%b rdy=%b want v=0 d=00000 rdy=0000",
                     bus4.out_valid, bus4.out_data, bus4.in_ready);
        end
        #1 rst_n = 1'b1;
        bus4.in_valid = 4'b0000;
    endtask

    task automatic test_direct_invalid;
        bus3.sel = 2'd0; bus3.in_valid = 3'b111;
        tick();
        vectors++;
        if (bus3.out_valid !== 1'b1 || bus3.out_chan !== 2'd0 || bus3.out_data !== D0) begin
            miscompares++;
            $display("FAIL c3_load got v=%b c=%0d d=%b want v=1 c=0 d=10101",
                     bus3.out_valid, bus3.out_chan, bus3.out_data);
        end
        bus3.sel = 2'd3;
        #1;
        vectors++;
        if (bus3.in_ready !== 3'b000) begin
            miscompares++; $display("FAIL c3_bad_sel_ready got %b want 000", bus3.in_ready);
        end
        tick();
        vectors++;
        if (bus3.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL c3_drain got v=%b want 0", bus3.out_valid);
        end
        tick();
        vectors++;
        if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 3'b000) begin
            miscompares++;
            $display("FAIL c3_idle got v=%b rdy=%b want v=0 rdy=000", bus3.out_valid, bus3.in_ready);
        end
        bus3.in_valid = 3'b000;
    endtask

    task automatic test_rr_fairness;
        int seq [9] = '{0, 1, 2, 3, 0, 1, 3, 0, 3};
        bus4.mode = 1'b1; bus4.out_ready = 1'b1; bus4.in_valid = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            if (i == 6) bus4.in_valid = 4'b1001;
            #1;
            vectors++;
            if (bus4.in_ready !== 4'(1 << seq[i])) begin
                miscompares++;
                $display("FAIL rr_ready[%0d] got %b want %b", i, bus4.in_ready, 4'(1 << seq[i]));
            end
            tick();
            vectors++;
            if (bus4.out_valid !== 1'b1 || bus4.out_chan !== 2'(seq[i]) || bus4.out_data !== chan_data(seq[i])) begin
                miscompares++;
                $display("FAIL rr_grant[%0d] got v=%b c=%0d d=%b want v=1 c=%0d d=%b", i,
                         bus4.out_valid, bus4.out_chan, bus4.out_data, seq[i], chan_data(seq[i]));
            end
        end
    endtask

    task automatic test_back_to_back;
        bus4.in_valid = 4'b0001;
        tick();
        vectors++;
        if (bus4.out_data !== D0 || bus4.out_chan !== 2'd0) begin
            miscompares++; $display("FAIL bp_load got d=%b c=%0d want d=10101 c=0", bus4.out_data, bus4.out_chan);
        end
        bus4.out_ready = 1'b0; bus4.in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (bus4.in_ready !== 4'b0000) begin
                miscompares++; $display("FAIL bp_ready[%0d] got %b want 0000", i, bus4.in_ready);
            end
            tick();
            vectors++;
            if (bus4.out_valid !== 1'b1 || bus4.out_data !== D0 || bus4.out_chan !== 2'd0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got v=%b d=%b c=%0d want v=1 d=10101 c=0", i,
                         bus4.out_valid, bus4.out_data, bus4.out_chan);
            end
        end
        bus4.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus4.in_ready !== 4'b0010) begin
            miscompares++; $display("FAIL bp_release_ready got %b want 0010", bus4.in_ready);
        end
        tick();
        vectors++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== D1 || bus4.out_chan !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_no_bubble got v=%b d=%b c=%0d want v=1 d=01010 c=1",
                     bus4.out_valid, bus4.out_data, bus4.out_chan);
        end
    endtask

    task automatic test_mode_switch;
        bus4.mode = 1'b0; bus4.sel = 2'd0; bus4.in_valid = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (bus4.in_ready !== 4'b0001) begin
                miscompares++; $display("FAIL ms_direct_ready[%0d] got %b want 0001", i, bus4.in_ready);
            end
            tick();
            vectors++;
            if (bus4.out_chan !== 2'd0 || bus4.out_data !== D0) begin
                miscompares++;
                $display("FAIL ms_direct[%0d] got c=%0d d=%b want c=0 d=10101", i, bus4.out_chan, bus4.out_data);
            end
        end
        bus4.mode = 1'b1;
        #1;
        vectors++;
        if (bus4.in_ready !== 4'b0100) begin
            miscompares++; $display("FAIL ms_rr_ready got %b want 0100", bus4.in_ready);
        end
        tick();
        vectors++;
        if (bus4.out_chan !== 2'd2 || bus4.out_data !== D2) begin
            miscompares++; $display("FAIL ms_rr_grant got c=%0d d=%b want c=2 d=00111", bus4.out_chan, bus4.out_data);
        end
    endtask

`ifdef MUX_RR_LOCK_EN
    task automatic test_lock;
        int seq [8] = '{3, 0, 1, 1, 1, 1, 1, 2};
        bus4.mode = 1'b1; bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus4.lock = (i >= 2 && i <= 5);
            if (i == 3) begin
                bus4.in_valid = 4'b1101;
                #1;
                vectors++;
                if (bus4.in_ready !== 4'b0010) begin
                    miscompares++; $display("FAIL lock_hold_ready got %b want 0010", bus4.in_ready);
                end
                bus4.in_valid = 4'b1111;
            end
            #1;
            tick();
            vectors++;
            if (bus4.out_chan !== 2'(seq[i])) begin
                miscompares++; $display("FAIL lock_grant[%0d] got c=%0d want c=%0d", i, bus4.out_chan, seq[i]);
            end
        end
        bus4.lock = 1'b0;
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_direct_invalid();
        test_rr_fairness();
        test_back_to_back();
        test_mode_switch();
`ifdef MUX_RR_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
